// File: rtl/utf8_stream_decoder.sv
// UTF-8 byte stream to 21-bit code point decoder with an output FIFO and paced,
// single-cycle code point pulses. Malformed input becomes REPLACEMENT and is counted.
module utf8_stream_decoder #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [20:0] REPLACEMENT = 21'h00FFFD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [20:0] unicode,
  output logic        unicode_available,
  input  logic        sink_ready,
  output logic [7:0]  error_count
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CP_W  = 21;

  typedef enum logic {LEAD, CONT} state_t;

  state_t          state, state_n;
  logic [1:0]      rem, rem_n;
  logic [2:0]      seqlen, seqlen_n;
  logic [CP_W-1:0] accum, accum_n;
  logic [CP_W-1:0] acc_shift;
  logic            seq_ok;

  logic            pending_valid;
  logic [7:0]      pending_byte;
  logic            pend_set;

  logic [7:0]      cur_byte;
  logic            active;
  logic            push, push_err, pop;
  logic [CP_W-1:0] push_data;

  logic [CP_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full, fifo_empty;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign byte_ready = !reset && !fifo_full && !pending_valid;

  // A latched pending byte takes priority over the input port and is replayed as a lead byte.
  assign cur_byte = pending_valid ? pending_byte : byte_in;
  assign active   = pending_valid ? !fifo_full : (byte_valid && byte_ready);
  assign pop      = !fifo_empty && sink_ready && !unicode_available;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LEAD;
      rem    <= '0;
      seqlen <= '0;
      accum  <= '0;
    end else begin
      state  <= state_n;
      rem    <= rem_n;
      seqlen <= seqlen_n;
      accum  <= accum_n;
    end
  end

  // Decoder next-state and push generation.
  always_comb begin
    state_n   = state;
    rem_n     = rem;
    seqlen_n  = seqlen;
    accum_n   = accum;
    push      = 1'b0;
    push_err  = 1'b0;
    push_data = '0;
    pend_set  = 1'b0;
    acc_shift = CP_W'({accum, cur_byte[5:0]});

    case (seqlen)
      3'd3:    seq_ok = (acc_shift >= 21'h000800) && (acc_shift[15:11] != 5'b11011);
      3'd4:    seq_ok = (acc_shift >= 21'h010000) && (acc_shift <= 21'h10FFFF);
      default: seq_ok = 1'b1;
    endcase

    if (active) begin
      case (state)
        LEAD: begin
          if (!cur_byte[7]) begin
            push      = 1'b1;
            push_data = CP_W'(cur_byte);
          end else if (cur_byte >= 8'hC2 && cur_byte <= 8'hDF) begin
            state_n  = CONT;
            rem_n    = 2'd1;
            seqlen_n = 3'd2;
            accum_n  = CP_W'(cur_byte[4:0]);
          end else if (cur_byte[7:4] == 4'hE) begin
            state_n  = CONT;
            rem_n    = 2'd2;
            seqlen_n = 3'd3;
            accum_n  = CP_W'(cur_byte[3:0]);
          end else if (cur_byte >= 8'hF0 && cur_byte <= 8'hF4) begin
            state_n  = CONT;
            rem_n    = 2'd3;
            seqlen_n = 3'd4;
            accum_n  = CP_W'(cur_byte[2:0]);
          end else begin
            push      = 1'b1;
            push_err  = 1'b1;
            push_data = REPLACEMENT;
          end
        end
        CONT: begin
          if (cur_byte[7:6] == 2'b10) begin
            if (rem == 2'd1) begin
              state_n   = LEAD;
              push      = 1'b1;
              push_err  = !seq_ok;
              push_data = seq_ok ? acc_shift : REPLACEMENT;
            end else begin
              rem_n   = rem - 2'd1;
              accum_n = acc_shift;
            end
          end else begin
            // Interrupted sequence: flag it, then reprocess the intruding byte as a lead byte.
            state_n   = LEAD;
            push      = 1'b1;
            push_err  = 1'b1;
            push_data = REPLACEMENT;
            pend_set  = 1'b1;
          end
        end
        default: state_n = LEAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_valid <= 1'b0;
      pending_byte  <= '0;
    end else if (pend_set) begin
      pending_valid <= 1'b1;
      pending_byte  <= byte_in;
    end else if (pending_valid && !fifo_full) begin
      pending_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and paced output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      unicode           <= '0;
      unicode_available <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      unicode_available <= pop;
      if (pop) unicode <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                              error_count <= '0;
    else if (push_err && error_count != 8'hFF) error_count <= error_count + 8'd1;
  end

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Directed scoreboard bench for utf8_stream_decoder: expected code points are queued
// as bytes are sent and compared against observed unicode_available pulses.
module tb_utf8_stream_decoder;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [20:0] unicode;
  logic        unicode_available;
  logic        sink_ready;
  logic [7:0]  error_count;

  utf8_stream_decoder #(.FIFO_DEPTH(16), .REPLACEMENT(21'h00FFFD)) dut (
    .clk               (clk),
    .reset             (reset),
    .byte_in           (byte_in),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .unicode           (unicode),
    .unicode_available (unicode_available),
    .sink_ready        (sink_ready),
    .error_count       (error_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [20:0] cp;
    int          c;
  } pulse_t;

  pulse_t      obs_q[$];
  logic [20:0] exp_q[$];
  int          got_cyc[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          acc_cyc  = 0;

  localparam logic [20:0] REPL = 21'h00FFFD;

  always @(negedge clk) begin
    if (unicode_available === 1'b1) obs_q.push_back('{unicode, cyc});
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Starts and ends on a falling edge; byte_valid drops at the end so sends can chain back-to-back.
  task automatic send(input logic [7:0] b);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    #1;
    while (byte_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("byte_ready_wait", 32'(byte_ready), 32'd1);
    if (byte_ready === 1'b1) @(posedge clk);
    @(negedge clk);
    acc_cyc    = cyc;
    byte_valid = 1'b0;
  endtask

  task automatic check_pulses(input string tag);
    int     n = 0;
    pulse_t p;
    got_cyc.delete();
    while (obs_q.size() < exp_q.size() && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk({tag, "_pulse_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      p = obs_q.pop_front();
      got_cyc.push_back(p.c);
      chk(tag, 32'(p.cp), 32'(exp_q.pop_front()));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("ready_in_reset", 32'(byte_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset      = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    sink_ready = 1'b1;

    // Reset state
    do_reset();
    #1;
    chk("rst_unicode", 32'(unicode), 32'd0);
    chk("rst_avail", 32'(unicode_available), 32'd0);
    chk("rst_err", 32'(error_count), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd1);
    @(negedge clk);

    // ASCII with latency check
    send(8'h41);
    exp_q.push_back(21'h000041);
    check_pulses("ascii");
    chk("ascii_latency", 32'(got_cyc.size() > 0 ? got_cyc[0] - acc_cyc : -1), 32'd1);
    chk("ascii_err", 32'(error_count), 32'd0);

    // Multi-byte sequences
    send(8'hC3); send(8'hA9);
    exp_q.push_back(21'h0000E9);
    check_pulses("two_byte");
    send(8'hE2); send(8'h82); send(8'hAC);
    exp_q.push_back(21'h0020AC);
    check_pulses("three_byte");
    send(8'hF0); send(8'h9F); send(8'h98); send(8'h80);
    exp_q.push_back(21'h01F600);
    check_pulses("four_byte");
    chk("multi_err", 32'(error_count), 32'd0);

    // Truncated sequence: intruding byte replayed through the pending register
    send(8'hE2);
    send(8'h41);
    #1;
    chk("trunc_ready_low", 32'(byte_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("trunc_ready_back", 32'(byte_ready), 32'd1);
    exp_q.push_back(REPL);
    exp_q.push_back(21'h000041);
    check_pulses("truncated");
    chk("trunc_err", 32'(error_count), 32'd1);

    // Invalid lead, overlong, surrogate and out-of-range sequences
    do_reset();
    send(8'hC0); send(8'h80);
    send(8'hED); send(8'hA0); send(8'h80);
    send(8'hF4); send(8'h90); send(8'h80); send(8'h80);
    repeat (4) exp_q.push_back(REPL);
    check_pulses("invalid");
    chk("invalid_err", 32'(error_count), 32'd4);

    // Backpressure: FIFO fills at 16, then drains with two-cycle spacing
    sink_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(8'h30 + 8'(i));
      exp_q.push_back(21'(8'h30 + 8'(i)));
    end
    byte_in    = 8'h60;
    byte_valid = 1'b1;
    #1;
    chk("bp_17th_ready", 32'(byte_ready), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("bp_17th_ready_hold", 32'(byte_ready), 32'd0);
    chk("bp_no_pulse", 32'(obs_q.size()), 32'd0);
    @(negedge clk);
    byte_valid = 1'b0;
    sink_ready = 1'b1;
    check_pulses("bp_drain");
    for (int i = 1; i < got_cyc.size(); i++) begin
      chk("bp_spacing", 32'(got_cyc[i] - got_cyc[i-1]), 32'd2);
    end

    // Reset in the middle of a sequence drops it silently
    send(8'hE2);
    send(8'h82);
    do_reset();
    repeat (8) @(negedge clk);
    chk("midrst_no_pulse", 32'(obs_q.size()), 32'd0);
    chk("midrst_err", 32'(error_count), 32'd0);
    chk("midrst_unicode", 32'(unicode), 32'd0);
    send(8'h41);
    exp_q.push_back(21'h000041);
    check_pulses("after_reset");
    chk("after_reset_err", 32'(error_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
